crc_stream_engine: RTL and testbench

- Parametrised streaming CRC engine; next generation of the SMBus PEC calculator.
- Handles any CRC width/polynomial up to 32 bits, with optional reflection, init value and final XOR.
- Accepts multi-byte beats with valid/ready flow control and byte enables. Emits one framed result per packet with expected-value compare and a mismatch counter.
- Used by the SMBus, SPI-flash and UART retro blocks.

---
 rtl/crc_stream_engine.sv | 128 ++++++++++++
 tb/tb_crc_stream_engine.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: multi-lane byte beats with keep, one framed result per
// packet held until consumed, with expected-value compare and mismatch count.
module crc_stream_engine #(
  parameter int          CRC_W  = 8,
  parameter logic [31:0] POLY   = 32'h07,
  parameter logic [31:0] INIT   = 32'h00,
  parameter logic [31:0] XOROUT = 32'h00,
  parameter bit          REFIN  = 1'b0,
  parameter bit          REFOUT = 1'b0,
  parameter int          LANES  = 1,
  parameter int          ERR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*LANES-1:0] s_data,
  input  logic [LANES-1:0]   s_keep,
  input  logic               s_last,
  input  logic [CRC_W-1:0]   chk_value,
  output logic [CRC_W-1:0]   crc_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CRC_W-1:0]   res_crc,
  output logic               res_match,
  output logic [ERR_W-1:0]   err_count
);

  localparam logic [CRC_W-1:0] P_POLY   = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] P_INIT   = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] P_XOROUT = XOROUT[CRC_W-1:0];

  typedef enum logic {S_ACCUM, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [CRC_W-1:0]  r_crc;
  logic [CRC_W-1:0]  r_resCrc;
  logic              r_resMatch;
  logic [ERR_W-1:0]  r_errCount;
  logic [CRC_W-1:0]  w_accNext;
  logic [CRC_W-1:0]  w_final;
  logic              w_match;
  logic              w_accept;
  logic              w_lastAccept;

  // One byte, MSB-first; the full 8 bits are shifted in even when CRC_W < 8.
  function automatic logic [CRC_W-1:0] crcByte(input logic [CRC_W-1:0] c,
                                               input logic [7:0] b);
    logic [CRC_W-1:0] acc;
    logic [7:0]       d;
    acc = c;
    for (int i = 0; i < 8; i++) d[i] = REFIN ? b[7-i] : b[i];
    for (int i = 7; i >= 0; i--) begin
      if (acc[CRC_W-1] ^ d[i]) acc = (acc << 1) ^ P_POLY;
      else                     acc = acc << 1;
    end
    return acc;
  endfunction

  function automatic logic [CRC_W-1:0] revCrc(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
    return r;
  endfunction

  assign s_ready      = !clear && ((r_state == S_ACCUM) || res_ready);
  assign w_accept     = s_valid && s_ready;
  assign w_lastAccept = w_accept && s_last;

  always_comb begin
    w_accNext = r_crc;
    for (int l = 0; l < LANES; l++) begin
      if (s_keep[l]) w_accNext = crcByte(w_accNext, s_data[8*l +: 8]);
    end
  end

  assign w_final = (REFOUT ? revCrc(w_accNext) : w_accNext) ^ P_XOROUT;
  assign w_match = (w_final == chk_value);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_ACCUM;
    else     r_state <= w_stateNext;
  end

  // In HOLD a beat is only accepted alongside res_ready, so a last beat there
  // is a back-to-back replace of the consumed result.
  always_comb begin
    w_stateNext = r_state;
    if (clear) begin
      w_stateNext = S_ACCUM;
    end else begin
      case (r_state)
        S_ACCUM: if (w_lastAccept) w_stateNext = S_HOLD;
        S_HOLD:  if (res_ready && !w_lastAccept) w_stateNext = S_ACCUM;
        default: w_stateNext = S_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc      <= P_INIT;
      r_resCrc   <= '0;
      r_resMatch <= 1'b0;
      r_errCount <= '0;
    end else if (clear) begin
      r_crc <= P_INIT;
    end else if (w_accept) begin
      if (s_last) begin
        r_crc      <= P_INIT;
        r_resCrc   <= w_final;
        r_resMatch <= w_match;
        if (!w_match && (r_errCount != '1)) r_errCount <= r_errCount + 1'b1;
      end else begin
        r_crc <= w_accNext;
      end
    end
  end

  assign crc_out   = r_crc;
  assign res_valid = (r_state == S_HOLD);
  assign res_crc   = r_resCrc;
  assign res_match = r_resMatch;
  assign err_count = r_errCount;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: SMBus PEC, CRC-16/CCITT-FALSE, CRC-32 and a
// narrow error counter instance, checked against hand-computed values.
module tb_crc_stream_engine;

  logic clk;
  logic rst;
  logic dRst;
  int   compared   = 0;
  int   mismatched = 0;
  int   aErrExp    = 0;

  // SMBus PEC instance
  logic        aClear, aValid, aReady, aLast, aResValid, aResReady, aResMatch;
  logic [7:0]  aData, aChk, aCrcOut, aResCrc;
  logic [0:0]  aKeep;
  logic [15:0] aErr;

  // CRC-16/CCITT-FALSE, 4 lanes
  logic        bClear, bValid, bReady, bLast, bResValid, bResReady, bResMatch;
  logic [31:0] bData;
  logic [3:0]  bKeep;
  logic [15:0] bChk, bCrcOut, bResCrc, bErr;

  // CRC-32, 8 lanes, reflected
  logic        cClear, cValid, cReady, cLast, cResValid, cResReady, cResMatch;
  logic [63:0] cData;
  logic [7:0]  cKeep;
  logic [31:0] cChk, cCrcOut, cResCrc;
  logic [15:0] cErr;

  // SMBus config with 4-bit error counter
  logic        dClear, dValid, dReady, dLast, dResValid, dResReady, dResMatch;
  logic [7:0]  dData, dChk, dCrcOut, dResCrc;
  logic [0:0]  dKeep;
  logic [3:0]  dErr;

  crc_stream_engine #(.CRC_W(8), .POLY(32'h07), .INIT(32'h0), .XOROUT(32'h0),
    .REFIN(1'b0), .REFOUT(1'b0), .LANES(1), .ERR_W(16)) uA (
    .clk(clk), .rst(rst), .clear(aClear), .s_valid(aValid), .s_ready(aReady),
    .s_data(aData), .s_keep(aKeep), .s_last(aLast), .chk_value(aChk),
    .crc_out(aCrcOut), .res_valid(aResValid), .res_ready(aResReady),
    .res_crc(aResCrc), .res_match(aResMatch), .err_count(aErr));

  crc_stream_engine #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .XOROUT(32'h0),
    .REFIN(1'b0), .REFOUT(1'b0), .LANES(4), .ERR_W(16)) uB (
    .clk(clk), .rst(rst), .clear(bClear), .s_valid(bValid), .s_ready(bReady),
    .s_data(bData), .s_keep(bKeep), .s_last(bLast), .chk_value(bChk),
    .crc_out(bCrcOut), .res_valid(bResValid), .res_ready(bResReady),
    .res_crc(bResCrc), .res_match(bResMatch), .err_count(bErr));

  crc_stream_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .XOROUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1), .LANES(8), .ERR_W(16)) uC (
    .clk(clk), .rst(rst), .clear(cClear), .s_valid(cValid), .s_ready(cReady),
    .s_data(cData), .s_keep(cKeep), .s_last(cLast), .chk_value(cChk),
    .crc_out(cCrcOut), .res_valid(cResValid), .res_ready(cResReady),
    .res_crc(cResCrc), .res_match(cResMatch), .err_count(cErr));

  crc_stream_engine #(.CRC_W(8), .POLY(32'h07), .INIT(32'h0), .XOROUT(32'h0),
    .REFIN(1'b0), .REFOUT(1'b0), .LANES(1), .ERR_W(4)) uD (
    .clk(clk), .rst(dRst), .clear(dClear), .s_valid(dValid), .s_ready(dReady),
    .s_data(dData), .s_keep(dKeep), .s_last(dLast), .chk_value(dChk),
    .crc_out(dCrcOut), .res_valid(dResValid), .res_ready(dResReady),
    .res_crc(dResCrc), .res_match(dResMatch), .err_count(dErr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] chk;
    logic [7:0] expCrc;
    logic       expMatch;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic readyOf(input int idx);
    case (idx)
      0:       return aReady;
      1:       return bReady;
      default: return cReady;
    endcase
  endfunction

  function automatic logic validOf(input int idx);
    case (idx)
      0:       return aResValid;
      1:       return bResValid;
      default: return cResValid;
    endcase
  endfunction

  // Called just after a negedge with inputs already driven; returns at the
  // negedge following the accepting posedge.
  task automatic waitAccept(input int idx, input string name);
    int n;
    n = 0;
    #1;
    while (!readyOf(idx) && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!readyOf(idx)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s ready timeout: got 0 want 1", name);
    end
    @(negedge clk);
  endtask

  task automatic aSend(input logic [7:0] d, input logic last, input logic [7:0] chk);
    aValid = 1'b1; aData = d; aKeep = 1'b1; aLast = last; aChk = chk;
    waitAccept(0, "aSend");
    aValid = 1'b0; aLast = 1'b0;
  endtask

  task automatic bSend(input logic [31:0] d, input logic [3:0] k, input logic last,
                       input logic [15:0] chk);
    bValid = 1'b1; bData = d; bKeep = k; bLast = last; bChk = chk;
    waitAccept(1, "bSend");
    bValid = 1'b0; bLast = 1'b0;
  endtask

  task automatic cSend(input logic [63:0] d, input logic [7:0] k, input logic last,
                       input logic [31:0] chk);
    cValid = 1'b1; cData = d; cKeep = k; cLast = last; cChk = chk;
    waitAccept(2, "cSend");
    cValid = 1'b0; cLast = 1'b0;
  endtask

  task automatic consume(input int idx);
    case (idx)
      0:       aResReady = 1'b1;
      1:       bResReady = 1'b1;
      default: cResReady = 1'b1;
    endcase
    @(negedge clk);
    aResReady = 1'b0; bResReady = 1'b0; cResReady = 1'b0;
    checkOutput("consume res_valid", {31'b0, validOf(idx)}, 32'h0);
  endtask

  task automatic applyStimulus(input vec_t v);
    aSend(v.data, 1'b1, v.chk);
    if (!v.expMatch) aErrExp++;
    checkOutput("vec res_valid", {31'b0, aResValid}, 32'h1);
    checkOutput("vec res_crc",   {24'b0, aResCrc}, {24'b0, v.expCrc});
    checkOutput("vec res_match", {31'b0, aResMatch}, {31'b0, v.expMatch});
    checkOutput("vec err_count", {16'b0, aErr}, aErrExp);
    checkOutput("vec crc_out",   {24'b0, aCrcOut}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b1};
    vecs[1] = '{8'h01, 8'h07, 8'h07, 1'b1};
    vecs[2] = '{8'h02, 8'h0E, 8'h0E, 1'b1};
    vecs[3] = '{8'h80, 8'h89, 8'h89, 1'b1};
    vecs[4] = '{8'hFF, 8'hF3, 8'hF3, 1'b1};
    vecs[5] = '{8'hFE, 8'hF4, 8'hF4, 1'b1};
    vecs[6] = '{8'h01, 8'h00, 8'h07, 1'b0};
    vecs[7] = '{8'h81, 8'h8E, 8'h8E, 1'b1};
    vecs[8] = '{8'h40, 8'h00, 8'hC7, 1'b0};

    rst = 1'b1; dRst = 1'b1;
    aClear = 0; aValid = 0; aLast = 0; aResReady = 0; aData = 0; aChk = 0; aKeep = 1;
    bClear = 0; bValid = 0; bLast = 0; bResReady = 0; bData = 0; bChk = 0; bKeep = 0;
    cClear = 0; cValid = 0; cLast = 0; cResReady = 0; cData = 0; cChk = 0; cKeep = 0;
    dClear = 0; dValid = 0; dLast = 0; dResReady = 0; dData = 0; dChk = 0; dKeep = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0; dRst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("a rst crc_out",   {24'b0, aCrcOut}, 32'h0);
    checkOutput("a rst res_valid", {31'b0, aResValid}, 32'h0);
    checkOutput("a rst res_crc",   {24'b0, aResCrc}, 32'h0);
    checkOutput("a rst res_match", {31'b0, aResMatch}, 32'h0);
    checkOutput("a rst err_count", {16'b0, aErr}, 32'h0);
    checkOutput("a rst s_ready",   {31'b0, aReady}, 32'h1);
    checkOutput("b rst crc_out",   {16'b0, bCrcOut}, 32'hFFFF);
    checkOutput("b rst res_valid", {31'b0, bResValid}, 32'h0);
    checkOutput("c rst crc_out",   cCrcOut, 32'hFFFFFFFF);
    checkOutput("c rst res_crc",   cResCrc, 32'h0);
    checkOutput("d rst err_count", {28'b0, dErr}, 32'h0);

    $display("[TB] SMBus PEC 123456789");
    aSend(8'h31, 1'b0, 8'h00);
    checkOutput("a crc_out after 1", {24'b0, aCrcOut}, 32'h97);
    for (int i = 2; i <= 8; i++) aSend(8'h30 + 8'(i), 1'b0, 8'h00);
    checkOutput("a res_valid mid-packet", {31'b0, aResValid}, 32'h0);
    aSend(8'h39, 1'b1, 8'hF4);
    checkOutput("a pec res_valid", {31'b0, aResValid}, 32'h1);
    checkOutput("a pec res_crc",   {24'b0, aResCrc}, 32'hF4);
    checkOutput("a pec res_match", {31'b0, aResMatch}, 32'h1);
    checkOutput("a pec err_count", {16'b0, aErr}, 32'h0);
    checkOutput("a pec crc_out",   {24'b0, aCrcOut}, 32'h0);
    consume(0);

    $display("[TB] SMBus single-byte vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      consume(0);
    end

    $display("[TB] backpressure");
    aSend(8'hFF, 1'b1, 8'hF3);
    aValid = 1'b1; aData = 8'h01; aLast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp s_ready", {31'b0, aReady}, 32'h0);
      @(negedge clk);
      checkOutput("bp res_valid", {31'b0, aResValid}, 32'h1);
      checkOutput("bp res_crc",   {24'b0, aResCrc}, 32'hF3);
    end
    checkOutput("bp crc_out untouched", {24'b0, aCrcOut}, 32'h0);
    aResReady = 1'b1; aData = 8'h00; aLast = 1'b1; aChk = 8'h00;
    #1;
    checkOutput("b2b s_ready", {31'b0, aReady}, 32'h1);
    @(negedge clk);
    aValid = 1'b0; aLast = 1'b0; aResReady = 1'b0;
    checkOutput("b2b res_valid", {31'b0, aResValid}, 32'h1);
    checkOutput("b2b res_crc",   {24'b0, aResCrc}, 32'h00);
    checkOutput("b2b res_match", {31'b0, aResMatch}, 32'h1);
    consume(0);

    $display("[TB] clear mid-packet and while holding");
    for (int i = 1; i <= 4; i++) aSend(8'h30 + 8'(i), 1'b0, 8'h00);
    aClear = 1'b1; aValid = 1'b1; aData = 8'h35;
    #1;
    checkOutput("clear s_ready", {31'b0, aReady}, 32'h0);
    @(negedge clk);
    aClear = 1'b0; aValid = 1'b0;
    checkOutput("clear crc_out", {24'b0, aCrcOut}, 32'h0);
    for (int i = 1; i <= 8; i++) aSend(8'h30 + 8'(i), 1'b0, 8'h00);
    aSend(8'h39, 1'b1, 8'hF4);
    checkOutput("post-clear res_crc",   {24'b0, aResCrc}, 32'hF4);
    checkOutput("post-clear res_match", {31'b0, aResMatch}, 32'h1);
    aClear = 1'b1;
    @(negedge clk);
    aClear = 1'b0;
    checkOutput("hold-clear res_valid", {31'b0, aResValid}, 32'h0);
    checkOutput("hold-clear err_count", {16'b0, aErr}, aErrExp);
    #1;
    checkOutput("hold-clear s_ready", {31'b0, aReady}, 32'h1);
    @(negedge clk);

    $display("[TB] CRC-16/CCITT-FALSE");
    bSend(32'h34333231, 4'b1111, 1'b0, 16'h0);
    bSend(32'h38373635, 4'b1111, 1'b0, 16'h0);
    bSend(32'hAAAAAA39, 4'b0001, 1'b1, 16'h29B1);
    checkOutput("b ccitt res_crc",   {16'b0, bResCrc}, 32'h29B1);
    checkOutput("b ccitt res_match", {31'b0, bResMatch}, 32'h1);
    checkOutput("b ccitt crc_out",   {16'b0, bCrcOut}, 32'hFFFF);
    consume(1);
    bSend(32'h32AA31AA, 4'b1010, 1'b0, 16'h0);
    bSend(32'h36353433, 4'b1111, 1'b0, 16'h0);
    bSend(32'hAA38AA37, 4'b0101, 1'b0, 16'h0);
    bSend(32'h39AAAAAA, 4'b1000, 1'b1, 16'h29B1);
    checkOutput("b sparse res_crc",   {16'b0, bResCrc}, 32'h29B1);
    checkOutput("b sparse res_match", {31'b0, bResMatch}, 32'h1);
    consume(1);
    bSend(32'h34333231, 4'b1111, 1'b0, 16'h0);
    bSend(32'h38373635, 4'b1111, 1'b0, 16'h0);
    bSend(32'hAAAAAA39, 4'b0001, 1'b0, 16'h0);
    bSend(32'hAAAAAAAA, 4'b0000, 1'b1, 16'h29B1);
    checkOutput("b empty-last res_crc", {16'b0, bResCrc}, 32'h29B1);
    consume(1);
    bSend(32'hAAAAAAAA, 4'b0000, 1'b1, 16'hFFFF);
    checkOutput("b empty-pkt res_valid", {31'b0, bResValid}, 32'h1);
    checkOutput("b empty-pkt res_crc",   {16'b0, bResCrc}, 32'hFFFF);
    checkOutput("b empty-pkt res_match", {31'b0, bResMatch}, 32'h1);
    checkOutput("b err_count",           {16'b0, bErr}, 32'h0);
    consume(1);

    $display("[TB] CRC-32");
    cSend(64'h3837363534333231, 8'hFF, 1'b0, 32'h0);
    cSend(64'hAAAAAAAAAAAAAA39, 8'h01, 1'b1, 32'hCBF43927);
    checkOutput("c bad res_crc",   cResCrc, 32'hCBF43926);
    checkOutput("c bad res_match", {31'b0, cResMatch}, 32'h0);
    checkOutput("c bad err_count", {16'b0, cErr}, 32'h1);
    checkOutput("c crc_out",       cCrcOut, 32'hFFFFFFFF);
    consume(2);
    cSend(64'h3837363534333231, 8'hFF, 1'b0, 32'h0);
    cSend(64'hAAAAAAAAAAAAAA39, 8'h01, 1'b1, 32'hCBF43926);
    checkOutput("c good res_crc",   cResCrc, 32'hCBF43926);
    checkOutput("c good res_match", {31'b0, cResMatch}, 32'h1);
    checkOutput("c good err_count", {16'b0, cErr}, 32'h1);
    consume(2);

    $display("[TB] error counter saturation");
    dValid = 1'b1; dLast = 1'b1; dData = 8'h01; dChk = 8'h00; dResReady = 1'b1;
    repeat (14) @(negedge clk);
    checkOutput("d err after 14", {28'b0, dErr}, 32'd14);
    repeat (5) @(negedge clk);
    checkOutput("d err saturated", {28'b0, dErr}, 32'd15);
    checkOutput("d res_crc",       {24'b0, dResCrc}, 32'h07);
    checkOutput("d res_match",     {31'b0, dResMatch}, 32'h0);
    dValid = 1'b0; dLast = 1'b0;
    @(negedge clk);
    checkOutput("d res_valid drained", {31'b0, dResValid}, 32'h0);
    dValid = 1'b1;
    @(negedge clk);
    dValid = 1'b0;
    checkOutput("d partial crc_out", {24'b0, dCrcOut}, 32'h07);
    dRst = 1'b1;
    @(negedge clk);
    dRst = 1'b0;
    checkOutput("d rst err_count", {28'b0, dErr}, 32'h0);
    checkOutput("d rst crc_out",   {24'b0, dCrcOut}, 32'h0);
    checkOutput("d rst res_valid", {31'b0, dResValid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
